// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan: multiplexed common-anode 4-digit 7-segment driver.
// Double-buffered BCD input (shadow -> disp at frame start), programmable
// dwell per digit and an all-off gap between digits.
// Optional build macro BCD_SEG_SCAN_LZB_EN enables leading-zero blanking.
module bcd_seg_scan #(
  parameter int PRESCALE  = 1000,
  parameter int BLANK_GAP = 2,
  parameter int CNT_W     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bcd_in,
  input  logic        load,
  output logic [6:0]  seg_n,
  output logic [3:0]  an_n,
  output logic [1:0]  digit_idx,
  output logic        frame_done
);

  typedef enum logic {ST_GAP, ST_DISPLAY} state_t;

  localparam state_t RST_STATE = (BLANK_GAP == 0) ? ST_DISPLAY : ST_GAP;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((BLANK_GAP > 0) ? BLANK_GAP - 1 : 0);
  localparam bit NO_GAP = (BLANK_GAP == 0);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [1:0]       idx_nx;
  logic             fd_nx;
  logic             started;
  logic             enter_disp;
  logic [15:0]      shadow, disp, disp_nx;
  logic [6:0]       seg_nx;
  logic [3:0]       an_nx;
  logic [3:0]       cur_digit;
  logic [3:0]       blank;

  // Active-low segment pattern, bit 6 = g ... bit 0 = a; non-BCD shows a dash.
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  // Next-state, counter, digit index and frame latch selection.
  // The first edge after reset release counts as entering the reset state,
  // so that state's cycle budget starts there (digit 0 lit at edge BLANK_GAP+1).
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    idx_nx     = digit_idx;
    fd_nx      = 1'b0;
    enter_disp = 1'b0;
    if (!started) begin
      enter_disp = (state == ST_DISPLAY);
    end else begin
      case (state)
        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            state_nx   = ST_DISPLAY;
            cnt_nx     = '0;
            enter_disp = 1'b1;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        default: begin
          if (cnt == DWELL_LAST) begin
            idx_nx = digit_idx + 2'd1;
            fd_nx  = (digit_idx == 2'd3);
            cnt_nx = '0;
            if (NO_GAP) begin
              state_nx   = ST_DISPLAY;
              enter_disp = 1'b1;
            end else begin
              state_nx = ST_GAP;
            end
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
      endcase
    end
    disp_nx = disp;
    if (enter_disp && idx_nx == 2'd0)
      disp_nx = load ? bcd_in : shadow;
  end

  // Leading-zero blanking flags and registered-output next values.
  always_comb begin
    cur_digit = disp_nx[{idx_nx, 2'b00} +: 4];
`ifdef BCD_SEG_SCAN_LZB_EN
    blank[3] = (disp_nx[15:12] == 4'd0);
    blank[2] = blank[3] && (disp_nx[11:8] == 4'd0);
    blank[1] = blank[2] && (disp_nx[7:4] == 4'd0);
    blank[0] = 1'b0;
`else
    blank = '0;
`endif
    an_nx  = '1;
    seg_nx = '1;
    if (state_nx == ST_DISPLAY) begin
      an_nx  = ~(4'b0001 << idx_nx);
      seg_nx = blank[idx_nx] ? 7'h7F : decode(cur_digit);
    end
  end

  // State, counter, buffers and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RST_STATE;
      cnt        <= '0;
      started    <= 1'b0;
      shadow     <= '0;
      disp       <= '0;
      seg_n      <= 7'h7F;
      an_n       <= 4'hF;
      digit_idx  <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      started    <= 1'b1;
      if (load)
        shadow <= bcd_in;
      disp       <= disp_nx;
      seg_n      <= seg_nx;
      an_n       <= an_nx;
      digit_idx  <= idx_nx;
      frame_done <= fd_nx;
    end
  end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Directed bench for bcd_seg_scan: one instance with PRESCALE=4/BLANK_GAP=2,
// one with PRESCALE=1/BLANK_GAP=0. Honours BCD_SEG_SCAN_LZB_EN for expectations.
module tb_bcd_seg_scan;

  localparam logic [6:0] S0   = 7'b1000000;
  localparam logic [6:0] S1   = 7'b1111001;
  localparam logic [6:0] S2   = 7'b0100100;
  localparam logic [6:0] S3   = 7'b0110000;
  localparam logic [6:0] S4   = 7'b0011001;
  localparam logic [6:0] S5   = 7'b0010010;
  localparam logic [6:0] S9   = 7'b0010000;
  localparam logic [6:0] SD   = 7'b0111111;
  localparam logic [6:0] OFF  = 7'h7F;
`ifdef BCD_SEG_SCAN_LZB_EN
  localparam logic [6:0] ZHI  = 7'h7F;
`else
  localparam logic [6:0] ZHI  = 7'b1000000;
`endif

  logic        clk = 1'b0;
  logic        reset, reset2;
  logic [15:0] bcd_in, bcd_in2;
  logic        load, load2;
  logic [6:0]  seg_n, seg_n2;
  logic [3:0]  an_n, an_n2;
  logic [1:0]  digit_idx, digit_idx2;
  logic        frame_done, frame_done2;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc   = 0;

  always #5 clk = ~clk;

  bcd_seg_scan #(.PRESCALE(4), .BLANK_GAP(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bcd_in(bcd_in), .load(load),
    .seg_n(seg_n), .an_n(an_n), .digit_idx(digit_idx), .frame_done(frame_done)
  );

  bcd_seg_scan #(.PRESCALE(1), .BLANK_GAP(0), .CNT_W(4)) dut0 (
    .clk(clk), .reset(reset2), .bcd_in(bcd_in2), .load(load2),
    .seg_n(seg_n2), .an_n(an_n2), .digit_idx(digit_idx2), .frame_done(frame_done2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go(input int unsigned c);
    while (cyc < c) step();
  endtask

  task automatic lit(input string tag, input logic [3:0] an_e, input logic [6:0] seg_e);
    chk({tag, ".an"}, {28'd0, an_n}, {28'd0, an_e});
    chk({tag, ".seg"}, {25'd0, seg_n}, {25'd0, seg_e});
  endtask

  initial begin
    reset = 1'b1; reset2 = 1'b1;
    bcd_in = 16'h0; load = 1'b0;
    bcd_in2 = 16'h0; load2 = 1'b0;
    #22;
    lit("rst", 4'hF, OFF);
    chk("rst.idx", {30'd0, digit_idx}, 32'd0);
    chk("rst.fd", {31'd0, frame_done}, 32'd0);
    @(negedge clk); reset = 1'b0; cyc = 0;

    // Frame 1: disp = 0000
    go(1);  lit("c1", 4'hF, OFF);
    go(2);  lit("c2", 4'hF, OFF);
    go(3);  lit("c3", 4'hE, S0);
    chk("c3.idx", {30'd0, digit_idx}, 32'd0);
    go(6);  lit("c6", 4'hE, S0);
    go(7);  lit("c7", 4'hF, OFF);
    chk("c7.idx", {30'd0, digit_idx}, 32'd1);
    go(9);  lit("c9", 4'hD, ZHI);
    go(10); bcd_in = 16'h1234; load = 1'b1;
    go(11); load = 1'b0; bcd_in = 16'h0000;
    go(15); lit("c15", 4'hB, ZHI);
    go(24); chk("c24.fd", {31'd0, frame_done}, 32'd0);
    go(25); chk("c25.fd", {31'd0, frame_done}, 32'd1);
    lit("c25", 4'hF, OFF);
    go(26); chk("c26.fd", {31'd0, frame_done}, 32'd0);

    // Frame 2: shadow 1234 latched
    go(27); lit("f2d0", 4'hE, S4);
    go(33); lit("f2d1", 4'hD, S3);
    go(39); lit("f2d2", 4'hB, S2);
    go(45); lit("f2d3", 4'h7, S1);

    // Frame 3: bypass load on the edge entering digit 0
    go(50); bcd_in = 16'h0905; load = 1'b1;
    go(51); load = 1'b0; bcd_in = 16'hFA09;
    lit("f3d0", 4'hE, S5);
    go(57); lit("f3d1", 4'hD, S0);
    go(60); load = 1'b1;
    go(61); load = 1'b0;
    go(63); lit("f3d2", 4'hB, S9);
    go(69); lit("f3d3", 4'h7, ZHI);

    // Frame 4: FA09
    go(75); lit("f4d0", 4'hE, S9);
    go(81); lit("f4d1", 4'hD, S0);
    go(87); lit("f4d2", 4'hB, SD);
    go(88);
    #2 reset = 1'b1;
    #1 lit("arst", 4'hF, OFF);
    chk("arst.idx", {30'd0, digit_idx}, 32'd0);
    step();
    @(negedge clk); reset = 1'b0; cyc = 0;
    go(2); lit("r2", 4'hF, OFF);
    go(3); lit("r3", 4'hE, S0);
    go(9); lit("r9", 4'hD, ZHI);

    // No-gap instance, PRESCALE=1
    chk("n.rst.an", {28'd0, an_n2}, 32'hF);
    @(negedge clk); reset2 = 1'b0; cyc = 0;
    go(1); chk("n1.an", {28'd0, an_n2}, 32'hE);
    chk("n1.seg", {25'd0, seg_n2}, {25'd0, S0});
    chk("n1.fd", {31'd0, frame_done2}, 32'd0);
    go(2); chk("n2.an", {28'd0, an_n2}, 32'hD);
    go(3); chk("n3.an", {28'd0, an_n2}, 32'hB);
    go(4); chk("n4.an", {28'd0, an_n2}, 32'h7);
    chk("n4.fd", {31'd0, frame_done2}, 32'd0);
    go(5); chk("n5.an", {28'd0, an_n2}, 32'hE);
    chk("n5.fd", {31'd0, frame_done2}, 32'd1);
    go(6); chk("n6.fd", {31'd0, frame_done2}, 32'd0);
    go(9); chk("n9.fd", {31'd0, frame_done2}, 32'd1);
    chk("n9.idx", {30'd0, digit_idx2}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_seg_scan.md
Name: bcd_seg_scan

Overview:
- Display stage downstream of the 4-digit BCD counter. Consumes the counter's packed 16-bit BCD value: digit 0 is bits [3:0], digit 3 is bits [15:12].
- Drives a multiplexed, common-anode 4-digit 7-segment display.
- Time-multiplexes the digits with a programmable dwell and an all-off ghosting gap between digits.
- Double-buffers the input so that a frame never shows a mix of two counter values.

Parameters:
- PRESCALE, 1000: clk cycles each digit is lit (DISPLAY dwell); legal range >= 1.
- BLANK_GAP, 2: clk cycles with all anodes off between digits; 0 removes the GAP state entirely.
- CNT_W, 16: width of the dwell/gap counter; must hold max(PRESCALE, BLANK_GAP) - 1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- bcd_in  in  16  packed BCD value from the counter
- load  in  1  capture strobe: bcd_in is sampled into the shadow register on any clk edge where load=1
- seg_n  out  7  active-low segments; bit 0=a … bit 6=g; registered
- an_n  out  4  active-low anode enables; an_n[i] selects digit i; registered
- digit_idx  out  2  digit currently selected (shown in DISPLAY, next to show in GAP)
- frame_done  out  1  one-cycle pulse when digit 3's dwell ends

Behaviour:
- Reset values:
  - seg_n=7'h7F, an_n=4'hF, digit_idx=0, frame_done=0.
  - shadow=0, disp=0, counter=0.
  - State = GAP, or DISPLAY if BLANK_GAP=0.
- Reset asserted mid-frame forces these values immediately, without waiting for a clock edge.
- States:
  - GAP: an_n=4'hF, seg_n=7'h7F. Lasts exactly BLANK_GAP cycles, then goes to DISPLAY.
  - DISPLAY: an_n has only bit digit_idx low; seg_n = decode of disp digit digit_idx. Lasts exactly PRESCALE cycles.
  - On leaving DISPLAY: digit_idx increments, wrapping 3 to 0, and the block enters GAP (or DISPLAY again if BLANK_GAP=0).
- Output timing: an_n and seg_n are registered and change on the same edge as the state transition.
  - After reset release with BLANK_GAP=2, digit 0 is lit starting at the 3rd rising edge.
- Frame latch: on each edge entering DISPLAY with digit_idx=0 (including the first after reset), disp <= shadow.
  - If load=1 on that same edge, disp takes bcd_in directly (bypass).
  - disp is constant for digits 0..3 of a frame.
- frame_done: high for exactly the one cycle following the final cycle of digit 3's DISPLAY. It coincides with the first GAP cycle, or with digit 0's first DISPLAY cycle if BLANK_GAP=0.
- Decode, active-low, g..a order:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Non-BCD nibble 10..15 shows dash: 0111111 (g only). This is not an error flag.
- load is ignored (shadow holds) when load=0. bcd_in is never sampled at any other time.
- Counter: counts 0 .. N-1 in each state, then reloads 0 on the transition. No other wrap-around exists.

Optional Feature:
- Macro BCD_SEG_SCAN_LZB_EN: leading-zero blanking.
- Defined:
  - Digit i (i = 3, 2, 1) is blanked (seg_n=7'h7F, anode still driven) when disp digit i = 0 and all more-significant disp digits = 0.
  - Digit 0 is never blanked.
  - Non-BCD digits count as non-zero.
  - Example: disp=16'h0047 shows 4 and 7; digits 3 and 2 are dark.
- Undefined: all four digits are always decoded, e.g. 0 0 4 7.
- Timing, an_n and frame_done are identical in both builds.

Test Plan (PRESCALE=4, BLANK_GAP=2 unless stated):
- Reset release, load=0 throughout:
  - Cycles 1-2: an_n=1111.
  - Cycles 3-6: an_n=1110, seg_n=1000000.
  - Cycles 7-8: off.
  - Cycles 9-12: an_n=1101.
  - Full frame is 24 cycles; frame_done pulses at cycle 25.
- load with bcd_in=16'h1234 during digit 1's dwell:
  - The current frame continues to show 0000.
  - The next frame shows digit0=4 (0011001), digit1=3, digit2=2, digit3=1 (1111001).
- load=1 exactly on the edge entering digit 0's DISPLAY, bcd_in=16'h0905:
  - That same frame shows 5, 0, 9, 0 (bypass path).
  - With BCD_SEG_SCAN_LZB_EN: digit 3 is blank and digit 1 shows 0, because a higher digit is non-zero.
- bcd_in=16'hFA09: digit 0 shows 0010000, digit 1 shows 1000000, digits 2 and 3 show dash 0111111.
- BLANK_GAP=0, PRESCALE=1:
  - an_n cycles 1110, 1101, 1011, 0111 on consecutive cycles, with no off cycles between digits.
  - frame_done is high in every 4th cycle, concurrent with digit 0.
- Assert reset asynchronously during digit 2's dwell: an_n=1111 and seg_n=7F before the next clk edge; the sequence restarts per the first scenario.
